// File: rtl/lma0_pkg.sv
// lma0 shared definitions: program-counter operation encoding.
package lma0_pkg;

    // Operation codes presented on pc_unit.op; codes 5-7 are reserved.
    typedef enum logic [2:0] {
        PC_INC    = 3'd0,
        PC_BRANCH = 3'd1,
        PC_JUMP   = 3'd2,
        PC_CALL   = 3'd3,
        PC_RET    = 3'd4
    } pc_op_e;

    localparam int unsigned PC_OP_W = 3;

endpackage : lma0_pkg

// File: rtl/pc_ras.sv
// Return-address stack: circular buffer with top pointer and entry count.
// A push into a full stack overwrites the oldest entry, so the count saturates.
module pc_ras #(
    parameter int unsigned WIDTH = 11,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           push_data,
    output logic [WIDTH-1:0]           top_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign top_data = mem_q[ptr_q];
    assign count    = count_q;

    // Next pointer, count and contents. The pointer wraps naturally since
    // DEPTH is a power of two; a full push lands on the oldest slot.
    always_comb begin
        ptr_d   = ptr_q;
        count_d = count_q;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (push) begin
            ptr_d        = ptr_q + PTR_W'(1);
            mem_d[ptr_d] = push_data;
            if (!full) begin
                count_d = count_q + CNT_W'(1);
            end
        end else if (pop && !empty) begin
            ptr_d   = ptr_q - PTR_W'(1);
            count_d = count_q - CNT_W'(1);
        end
    end

    // Pointer and count registers; synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q   <= '0;
            count_q <= '0;
        end else begin
            ptr_q   <= ptr_d;
            count_q <= count_d;
        end
    end

    // Stack storage; contents are don't-care after reset, so no reset here.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
        end
    end

endmodule : pc_ras

// File: rtl/pc_unit.sv
// lma0 program-counter unit: registered PC with increment, relative branch,
// absolute jump and call/return through a small return-address stack.
module pc_unit
    import lma0_pkg::*;
#(
    parameter int unsigned PC_WIDTH  = 11,
    parameter int unsigned OFF_WIDTH = 8,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         en,
    input  logic [PC_OP_W-1:0]           op,
    input  logic                         cond,
    input  logic [OFF_WIDTH-1:0]         offset,
    input  logic [PC_WIDTH-1:0]          target,
    input  logic                         clr_err,
    output logic [PC_WIDTH-1:0]          pc,
    output logic [$clog2(RAS_DEPTH):0]   ras_count,
    output logic                         ras_overflow,
    output logic                         ras_underflow
);

    pc_op_e               op_e;
    logic [PC_WIDTH-1:0]  pc_q, pc_d;
    logic [PC_WIDTH-1:0]  pc_inc;
    logic [PC_WIDTH-1:0]  off_ext;
    logic                 ovf_q, ovf_d;
    logic                 unf_q, unf_d;
    logic                 is_call, is_ret;
    logic                 ras_push, ras_pop;
    logic                 ras_full, ras_empty;
    logic [PC_WIDTH-1:0]  ras_top;

    assign op_e    = pc_op_e'(op);
    assign pc_inc  = pc_q + PC_WIDTH'(1);
    // Sized cast of a signed value sign-extends to the PC width.
    assign off_ext = PC_WIDTH'($signed(offset));

    assign is_call  = en && (op_e == PC_CALL);
    assign is_ret   = en && (op_e == PC_RET);
    assign ras_push = is_call;
    assign ras_pop  = is_ret && !ras_empty;

    pc_ras #(
        .WIDTH (PC_WIDTH),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (pc_inc),
        .top_data  (ras_top),
        .count     (ras_count),
        .full      (ras_full),
        .empty     (ras_empty)
    );

    // Next-pc selection; reserved opcodes fall through to increment.
    always_comb begin
        pc_d = pc_q;
        if (en) begin
            case (op_e)
                PC_BRANCH: pc_d = cond ? (pc_q + off_ext) : pc_inc;
                PC_JUMP:   pc_d = target;
                PC_CALL:   pc_d = target;
                PC_RET:    pc_d = ras_empty ? pc_inc : ras_top;
                default:   pc_d = pc_inc;
            endcase
        end
    end

    // Sticky stack error flags; a set in the same cycle wins over clr_err.
    always_comb begin
        ovf_d = (is_call && ras_full)  || (ovf_q && !clr_err);
        unf_d = (is_ret  && ras_empty) || (unf_q && !clr_err);
    end

    // PC and flag registers; synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q  <= RESET_PC;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign pc            = pc_q;
    assign ras_overflow  = ovf_q;
    assign ras_underflow = unf_q;

endmodule : pc_unit

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios plus randomized
// traffic, compared each cycle against a queue-based reference model.
module tb_pc_unit;

    localparam int unsigned PC_W   = 11;
    localparam int unsigned OFF_W  = 8;
    localparam int unsigned DEPTH  = 4;
    localparam int          RST_PC = 'h100;
    localparam int          MASK   = (1 << PC_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              en;
    logic [2:0]        op;
    logic              cond;
    logic [OFF_W-1:0]  offset;
    logic [PC_W-1:0]   target;
    logic              clr_err;
    logic [PC_W-1:0]   pc;
    logic [$clog2(DEPTH):0] ras_count;
    logic              ras_overflow;
    logic              ras_underflow;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int m_pc;
    int m_stack[$];
    bit m_ovf, m_unf;

    always #5 clk = ~clk;

    pc_unit #(
        .PC_WIDTH  (PC_W),
        .OFF_WIDTH (OFF_W),
        .RESET_PC  (PC_W'(RST_PC)),
        .RAS_DEPTH (DEPTH)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .en            (en),
        .op            (op),
        .cond          (cond),
        .offset        (offset),
        .target        (target),
        .clr_err       (clr_err),
        .pc            (pc),
        .ras_count     (ras_count),
        .ras_overflow  (ras_overflow),
        .ras_underflow (ras_underflow)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Apply one edge of the architectural rules to the model.
    task automatic model_edge();
        bit ovs, uns;
        int off;
        ovs = 0;
        uns = 0;
        if (!rst_n) begin
            m_pc = RST_PC;
            m_stack.delete();
            m_ovf = 0;
            m_unf = 0;
        end else begin
            if (en) begin
                case (op)
                    3'd1: begin
                        off  = int'($signed(offset));
                        m_pc = cond ? m_pc + off : m_pc + 1;
                    end
                    3'd2: m_pc = int'(target);
                    3'd3: begin
                        if (m_stack.size() == DEPTH) begin
                            void'(m_stack.pop_front());
                            ovs = 1;
                        end
                        m_stack.push_back((m_pc + 1) & MASK);
                        m_pc = int'(target);
                    end
                    3'd4: begin
                        if (m_stack.size() > 0) m_pc = m_stack.pop_back();
                        else begin
                            m_pc = m_pc + 1;
                            uns  = 1;
                        end
                    end
                    default: m_pc = m_pc + 1;
                endcase
                m_pc = m_pc & MASK;
            end
            m_ovf = ovs || (m_ovf && !clr_err);
            m_unf = uns || (m_unf && !clr_err);
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".pc"},  32'(pc),            32'(m_pc));
        check({tag, ".cnt"}, 32'(ras_count),     32'(m_stack.size()));
        check({tag, ".ovf"}, 32'(ras_overflow),  32'(m_ovf));
        check({tag, ".unf"}, 32'(ras_underflow), 32'(m_unf));
    endtask

    // Drive one cycle on the falling edge, update model at the rising edge,
    // and sample outputs shortly after it.
    task automatic step(input string tag, input bit rn, input bit e, input int o,
                        input bit c, input int off, input int tgt, input bit clr);
        @(negedge clk);
        rst_n   = rn;
        en      = e;
        op      = 3'(o);
        cond    = c;
        offset  = OFF_W'(off);
        target  = PC_W'(tgt);
        clr_err = clr;
        @(posedge clk);
        model_edge();
        #1;
        compare_all(tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; en = 1'b0; op = '0; cond = 1'b0;
        offset = '0; target = '0; clr_err = 1'b0;
        m_pc = 0; m_ovf = 0; m_unf = 0;

        // Reset then three increments
        step("rst", 0, 1, 0, 0, 0, 0, 0);
        check("rst_pc_lit", 32'(pc), 32'h100);
        for (int i = 0; i < 3; i++) step("inc", 1, 1, 0, 0, 0, 0, 0);
        check("inc3_pc_lit", 32'(pc), 32'h103);

        // Wrap from all-ones, then stall with JUMP presented
        step("jmp7ff", 1, 1, 2, 0, 0, 'h7FF, 0);
        step("wrap", 1, 1, 0, 0, 0, 0, 0);
        check("wrap_pc_lit", 32'(pc), 32'h000);
        for (int i = 0; i < 5; i++) step("stall", 1, 0, 2, 0, 0, 'h555, 0);
        check("stall_pc_lit", 32'(pc), 32'h000);

        // Branch taken backwards, then not taken
        step("jmp010", 1, 1, 2, 0, 0, 'h010, 0);
        step("br_t", 1, 1, 1, 1, 'hFD, 0, 0);
        check("br_t_lit", 32'(pc), 32'h00D);
        step("br_nt", 1, 1, 1, 0, 'h05, 0, 0);
        check("br_nt_lit", 32'(pc), 32'h00E);

        // Overflow: five calls into a four-entry stack
        step("jmp020", 1, 1, 2, 0, 0, 'h020, 0);
        for (int i = 0; i < 5; i++) step("call", 1, 1, 3, 0, 0, 'h030 + 'h10 * i, 0);
        check("ovf_lit", 32'(ras_overflow), 32'd1);
        check("ovf_cnt_lit", 32'(ras_count), 32'd4);
        step("ret1", 1, 1, 4, 0, 0, 0, 0); check("ret1_lit", 32'(pc), 32'h061);
        step("ret2", 1, 1, 4, 0, 0, 0, 0); check("ret2_lit", 32'(pc), 32'h051);
        step("ret3", 1, 1, 4, 0, 0, 0, 0); check("ret3_lit", 32'(pc), 32'h041);
        step("ret4", 1, 1, 4, 0, 0, 0, 0); check("ret4_lit", 32'(pc), 32'h031);
        step("ret5", 1, 1, 4, 0, 0, 0, 0); check("ret5_lit", 32'(pc), 32'h032);
        check("unf_lit", 32'(ras_underflow), 32'd1);

        // Error clearing, and set-wins-over-clear
        step("clr", 1, 1, 0, 0, 0, 0, 1);
        check("clr_ovf_lit", 32'(ras_overflow), 32'd0);
        check("clr_unf_lit", 32'(ras_underflow), 32'd0);
        step("clr_vs_set", 1, 1, 4, 0, 0, 0, 1);
        check("setwins_lit", 32'(ras_underflow), 32'd1);
        step("clr_stall", 1, 0, 0, 0, 0, 0, 1);
        check("clr_stall_lit", 32'(ras_underflow), 32'd0);

        // Back-to-back call/return
        step("bb_call", 1, 1, 3, 0, 0, 'h3AA, 0);
        step("bb_ret", 1, 1, 4, 0, 0, 0, 0);

        // Reset mid-operation
        step("mid_call1", 1, 1, 3, 0, 0, 'h200, 0);
        step("mid_call2", 1, 1, 3, 0, 0, 'h300, 0);
        step("mid_rst", 0, 1, 3, 0, 0, 'h400, 0);
        check("mid_rst_cnt_lit", 32'(ras_count), 32'd0);
        step("post_rst_ret", 1, 1, 4, 0, 0, 0, 0);
        check("post_rst_unf_lit", 32'(ras_underflow), 32'd1);
        check("post_rst_pc_lit", 32'(pc), 32'h101);

        // Randomized traffic, weighted toward stack operations
        for (int i = 0; i < 600; i++) begin
            int  r, o;
            bit  rn, e, c, clr;
            r   = int'($urandom_range(0, 99));
            o   = (r < 25) ? 3 : (r < 50) ? 4 : int'($urandom_range(0, 7));
            rn  = ($urandom_range(0, 99) >= 2);
            e   = ($urandom_range(0, 99) < 85);
            c   = 1'($urandom);
            clr = ($urandom_range(0, 99) < 10);
            step("rand", rn, e, o, c, int'($urandom_range(0, 255)),
                 int'($urandom_range(0, MASK)), clr);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_pc_unit
